// File: rtl/attention_tile_scheduler.sv
// Tile-loop sequencer for tiled attention: walks query tiles and their kv tiles,
// issuing one command at a time to the datapath/loader and waiting for completion.
module attention_tile_scheduler #(
  parameter int IDX_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 causal,
  input  logic [IDX_WIDTH-1:0] num_q_tiles,
  input  logic [IDX_WIDTH-1:0] num_kv_tiles,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [2:0]           cmd_op,
  output logic [IDX_WIDTH-1:0] cmd_q_idx,
  output logic [IDX_WIDTH-1:0] cmd_kv_idx,
  output logic                 cmd_first,
  output logic                 cmd_last,
  input  logic                 op_done,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] cmd_count
);

  localparam int XW = IDX_WIDTH + 1;

  localparam logic [2:0] OP_LOAD_Q  = 3'd0;
  localparam logic [2:0] OP_LOAD_K  = 3'd1;
  localparam logic [2:0] OP_PV      = 3'd5;
  localparam logic [2:0] OP_NORM    = 3'd6;
  localparam logic [2:0] OP_STORE   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [IDX_WIDTH-1:0] qi_q, qi_d;
  logic [IDX_WIDTH-1:0] kj_q, kj_d;
  logic [IDX_WIDTH-1:0] nq_q, nq_d;
  logic [IDX_WIDTH-1:0] nkv_q, nkv_d;
  logic                 causal_q, causal_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Index math is one bit wider so i+1 and j+1 never wrap at the maximum tile count.
  logic [XW-1:0] qi_inc, kj_inc, kv_lim;
  logic          is_kv_op, last_kv, last_q;

  assign qi_inc   = {1'b0, qi_q} + XW'(1);
  assign kj_inc   = {1'b0, kj_q} + XW'(1);
  assign kv_lim   = (causal_q && (qi_inc < {1'b0, nkv_q})) ? qi_inc : {1'b0, nkv_q};
  assign is_kv_op = (op_q >= OP_LOAD_K) && (op_q <= OP_PV);
  assign last_kv  = (kj_inc == kv_lim);
  assign last_q   = (qi_inc == {1'b0, nq_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_LOAD_Q;
      qi_q     <= '0;
      kj_q     <= '0;
      nq_q     <= '0;
      nkv_q    <= '0;
      causal_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      qi_q     <= qi_d;
      kj_q     <= kj_d;
      nq_q     <= nq_d;
      nkv_q    <= nkv_d;
      causal_q <= causal_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    qi_d     = qi_q;
    kj_d     = kj_q;
    nq_d     = nq_q;
    nkv_d    = nkv_q;
    causal_d = causal_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      // op_done is only legal while a command is outstanding
      if (op_done && (state_q != S_WAIT)) err_d = 1'b1;
      if (start && (state_q != S_IDLE))   err_d = 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            causal_d = causal;
            nq_d     = num_q_tiles;
            nkv_d    = num_kv_tiles;
            op_d     = OP_LOAD_Q;
            qi_d     = '0;
            kj_d     = '0;
            cnt_d    = '0;
            err_d    = op_done;
            state_d  = ((num_q_tiles == '0) || (num_kv_tiles == '0)) ? S_FINISH : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            state_d = S_WAIT;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        S_WAIT: begin
          if (op_done) begin
            state_d = S_ISSUE;
            unique case (op_q)
              OP_PV: begin
                if (last_kv) begin
                  op_d = OP_NORM;
                  kj_d = '0;
                end else begin
                  op_d = OP_LOAD_K;
                  kj_d = kj_inc[IDX_WIDTH-1:0];
                end
              end
              OP_NORM: op_d = OP_STORE;
              OP_STORE: begin
                if (last_q) begin
                  state_d = S_FINISH;
                end else begin
                  op_d = OP_LOAD_Q;
                  qi_d = qi_inc[IDX_WIDTH-1:0];
                end
              end
              default: op_d = op_q + 3'd1;
            endcase
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_valid  = (state_q == S_ISSUE);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_FINISH);
    cmd_op     = op_q;
    cmd_q_idx  = qi_q;
    cmd_kv_idx = kj_q;
    cmd_first  = is_kv_op && (kj_q == '0);
    cmd_last   = is_kv_op && last_kv;
    err        = err_q;
    cmd_count  = cnt_q;
  end

endmodule

// File: tb/tb_attention_tile_scheduler.sv
// Directed bench for attention_tile_scheduler: a table of jobs driven through a
// datapath responder, plus hand-written reset, error and interruption sequences.
module tb_attention_tile_scheduler;
  localparam int IW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort, causal, cmd_ready, op_done;
  logic [IW-1:0] num_q_tiles, num_kv_tiles;
  logic          cmd_valid, cmd_first, cmd_last, busy, done, err;
  logic [2:0]    cmd_op;
  logic [IW-1:0] cmd_q_idx, cmd_kv_idx;
  logic [CW-1:0] cmd_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  attention_tile_scheduler #(.IDX_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .causal(causal),
    .num_q_tiles(num_q_tiles), .num_kv_tiles(num_kv_tiles),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_q_idx(cmd_q_idx), .cmd_kv_idx(cmd_kv_idx),
    .cmd_first(cmd_first), .cmd_last(cmd_last), .op_done(op_done),
    .busy(busy), .done(done), .err(err), .cmd_count(cmd_count)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] q;
    logic [15:0] kv;
    logic        first;
    logic        last;
  } cmd_t;

  typedef struct {
    bit causal;
    int nq;
    int nkv;
    int exp_cmds;
    bit stall;
    bit dup_start;
    bit abort_lv;
    int exp_done;
    bit exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [2:0] op, input logic [15:0] q,
                                     input logic [15:0] kv, input logic f, input logic l);
    pk = {17'd0, op, 4'd0, q, kv, 3'd0, f, 3'd0, l};
  endfunction

  function automatic logic [63:0] out_pack();
    out_pack = 64'({cmd_valid, cmd_op, cmd_q_idx, cmd_kv_idx, cmd_first, cmd_last,
                    busy, done, err, cmd_count});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int idx, input vec_t v);
    cmd_t        exp_q[$];
    cmd_t        e;
    int          jn, cyc, pending, n_acc, n_done, last_ev, stall_cnt, busy_cyc;
    bit          fin, abort_next;
    logic [63:0] held;
    if (v.nq != 0 && v.nkv != 0) begin
      for (int i = 0; i < v.nq; i++) begin
        jn = (v.causal && (i + 1 < v.nkv)) ? i + 1 : v.nkv;
        e = '{3'd0, 16'(i), 16'd0, 1'b0, 1'b0};
        exp_q.push_back(e);
        for (int j = 0; j < jn; j++) begin
          for (int op = 1; op <= 5; op++) begin
            e = '{3'(op), 16'(i), 16'(j), (j == 0), (j == jn - 1)};
            exp_q.push_back(e);
          end
        end
        e = '{3'd6, 16'(i), 16'd0, 1'b0, 1'b0};
        exp_q.push_back(e);
        e = '{3'd7, 16'(i), 16'd0, 1'b0, 1'b0};
        exp_q.push_back(e);
      end
    end
    causal       = v.causal;
    num_q_tiles  = IW'(v.nq);
    num_kv_tiles = IW'(v.nkv);
    start        = 1'b1;
    tick();
    start = 1'b0;
    chk($sformatf("v%0d err_clear_on_start", idx), 64'(err), 64'd0);
    cyc = 0; pending = 0; n_acc = 0; n_done = 0; last_ev = -1;
    stall_cnt = 0; busy_cyc = 0; fin = 1'b0; abort_next = 1'b0; held = '0;
    while (!fin) begin
      op_done   = 1'b0;
      cmd_ready = 1'b1;
      abort     = 1'b0;
      start     = 1'b0;
      if (!busy) begin
        fin = 1'b1;
      end else if (cyc >= 20000) begin
        checks++;
        errors++;
        $display("FAIL v%0d timeout: busy still %0b after %0d cycles", idx, busy, cyc);
        fin = 1'b1;
      end else begin
        busy_cyc++;
        if (abort_next) begin
          abort      = 1'b1;
          pending    = 0;
          abort_next = 1'b0;
        end else if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            op_done = 1'b1;
            last_ev = cyc;
          end
        end
        if (done) begin
          n_done++;
          chk($sformatf("v%0d done_timing", idx), 64'(cyc), 64'(last_ev + 1));
        end
        if (v.stall && cmd_valid && cmd_op == 3'd2 && cmd_q_idx == 8'd1 &&
            cmd_kv_idx == 8'd2 && stall_cnt < 5) begin
          cmd_ready = 1'b0;
          if (stall_cnt == 0)
            held = pk(cmd_op, 16'(cmd_q_idx), 16'(cmd_kv_idx), cmd_first, cmd_last);
          else
            chk($sformatf("v%0d stall_stable", idx),
                pk(cmd_op, 16'(cmd_q_idx), 16'(cmd_kv_idx), cmd_first, cmd_last), held);
          chk($sformatf("v%0d stall_count", idx), 64'(cmd_count), 64'(n_acc));
          stall_cnt++;
        end
        if (cmd_valid && cmd_ready) begin
          chk($sformatf("v%0d accept_count", idx), 64'(cmd_count), 64'(n_acc));
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL v%0d extra_cmd: got op=%0d q=%0d kv=%0d, required no command",
                     idx, cmd_op, cmd_q_idx, cmd_kv_idx);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("v%0d cmd_seq#%0d", idx, n_acc),
                pk(cmd_op, 16'(cmd_q_idx), 16'(cmd_kv_idx), cmd_first, cmd_last),
                pk(e.op, e.q, e.kv, e.first, e.last));
          end
          n_acc++;
          pending = 3;
          if (v.dup_start && n_acc == 5) start = 1'b1;
          if (v.abort_lv && cmd_op == 3'd4 && cmd_q_idx == 8'd0 && cmd_kv_idx == 8'd1)
            abort_next = 1'b1;
        end
        tick();
        cyc++;
      end
    end
    chk($sformatf("v%0d n_cmds", idx), 64'(n_acc), 64'(v.exp_cmds));
    chk($sformatf("v%0d done_pulses", idx), 64'(n_done), 64'(v.exp_done));
    chk($sformatf("v%0d err", idx), 64'(err), 64'(v.exp_err));
    chk($sformatf("v%0d cmd_count", idx), 64'(cmd_count), 64'(v.exp_cmds));
    chk($sformatf("v%0d cmd_valid_after", idx), 64'(cmd_valid), 64'd0);
    if (v.nq == 0 || v.nkv == 0)
      chk($sformatf("v%0d busy_cycles", idx), 64'(busy_cyc), 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; causal = 1'b0;
    cmd_ready = 1'b0; op_done = 1'b0; num_q_tiles = '0; num_kv_tiles = '0;

    //        causal nq   nkv  cmds  stall dup  abort done err
    vecs[0]  = '{1'b0, 2,   3,   36,   1'b0, 1'b0, 1'b0, 1, 1'b0};
    vecs[1]  = '{1'b1, 3,   2,   34,   1'b0, 1'b0, 1'b0, 1, 1'b0};
    vecs[2]  = '{1'b0, 0,   3,   0,    1'b0, 1'b0, 1'b0, 1, 1'b0};
    vecs[3]  = '{1'b0, 2,   0,   0,    1'b0, 1'b0, 1'b0, 1, 1'b0};
    vecs[4]  = '{1'b0, 2,   3,   36,   1'b1, 1'b0, 1'b0, 1, 1'b0};
    vecs[5]  = '{1'b0, 2,   3,   36,   1'b0, 1'b1, 1'b0, 1, 1'b1};
    vecs[6]  = '{1'b1, 1,   1,   8,    1'b0, 1'b0, 1'b0, 1, 1'b0};
    vecs[7]  = '{1'b0, 2,   3,   10,   1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[8]  = '{1'b0, 1,   255, 1278, 1'b0, 1'b0, 1'b0, 1, 1'b0};
    vecs[9]  = '{1'b1, 3,   255, 39,   1'b0, 1'b0, 1'b0, 1, 1'b0};
    vecs[10] = '{1'b1, 255, 1,   2040, 1'b0, 1'b0, 1'b0, 1, 1'b0};

    repeat (3) tick();
    rst = 1'b0;
    chk("reset_outputs", out_pack(), 64'd0);

    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    chk("idle_opdone_err", 64'(err), 64'd1);
    chk("idle_opdone_quiet", 64'({cmd_valid, busy, cmd_count}), 64'd0);
    tick();

    for (int k = 0; k < 8; k++) begin
      run_job(k, vecs[k]);
      tick();
    end

    causal = 1'b0; num_q_tiles = 8'd1; num_kv_tiles = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cmd_ready = 1'b1;
    chk("rst_seq_issue", 64'({cmd_valid, cmd_op}), 64'({1'b1, 3'd0}));
    tick();
    cmd_ready = 1'b0;
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    chk("rst_seq_loadk", 64'({cmd_valid, cmd_op, cmd_count}), 64'({1'b1, 3'd1, 16'd1}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_issue", out_pack(), 64'd0);
    tick();

    for (int k = 8; k < 11; k++) begin
      run_job(k, vecs[k]);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/attention_tile_scheduler.md
Name: attention_tile_scheduler

Overview:
- Sequences tiled attention over the shared Q·K / softmax / P·V datapath, one query tile at a time.
- Implements the tile-loop control: load Q, stream K/V tiles with a running-softmax update, normalize, store.
- Issues one command at a time to the datapath/loader over a valid/ready channel and waits for a completion pulse.
- Sits between the host control registers and the attention datapath plus its tile loader.

Parameters:
- IDX_WIDTH, 8, width of tile-count and tile-index fields.
- CNT_WIDTH, 16, width of the accepted-command counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle job start; honoured only in IDLE
- abort  input  1  return to IDLE; takes priority over all other inputs except rst
- causal  input  1  causal masking; latched at start
- num_q_tiles  input  IDX_WIDTH  query tile count Nq; latched at start
- num_kv_tiles  input  IDX_WIDTH  key/value tile count Nkv; latched at start
- cmd_valid  output  1  command presented
- cmd_ready  input  1  datapath accepts command
- cmd_op  output  3  0 LOAD_Q, 1 LOAD_K, 2 QK, 3 SOFTMAX, 4 LOAD_V, 5 PV, 6 NORM, 7 STORE
- cmd_q_idx  output  IDX_WIDTH  current query tile i
- cmd_kv_idx  output  IDX_WIDTH  current kv tile j (0 for LOAD_Q/NORM/STORE)
- cmd_first  output  1  j==0; datapath resets running max and sum
- cmd_last  output  1  j is the last kv tile for tile i
- op_done  input  1  one-cycle completion of the outstanding command
- busy  output  1  job in progress
- done  output  1  one-cycle pulse at job completion
- err  output  1  sticky protocol error; cleared by rst or start
- cmd_count  output  CNT_WIDTH  commands accepted in the current job; saturates

Behaviour:
- All flops use synchronous reset.
- Reset values: cmd_valid=0, cmd_op=0, cmd_q_idx=0, cmd_kv_idx=0, cmd_first=0, cmd_last=0, busy=0, done=0, err=0, cmd_count=0, state=IDLE.
- States: IDLE, ISSUE (cmd_valid high, waiting for cmd_ready), WAIT (command accepted, waiting for op_done), FINISH.
- Per-tile kv count: J(i) = causal ? min(i+1, Nkv) : Nkv.
- Command order for each i = 0..Nq-1:
  - LOAD_Q
  - then for each j = 0..J(i)-1: LOAD_K, QK, SOFTMAX, LOAD_V, PV
  - then NORM, STORE
  - Commands per tile = 3 + 5·J(i).
- cmd_first and cmd_last are valid on every op; both are 0 for LOAD_Q, NORM and STORE.
- Start:
  - start in IDLE latches causal, Nq and Nkv, clears err and cmd_count, and sets busy.
  - If Nq==0 or Nkv==0: go to FINISH, issue no commands.
  - Otherwise: enter ISSUE on the next cycle with LOAD_Q, i=0.
- Handshake:
  - In ISSUE, cmd_valid is high and all cmd_* fields stay stable until the cycle where cmd_valid&&cmd_ready.
  - In that accept cycle: cmd_count increments and the state goes to WAIT; cmd_valid is low from the next cycle.
  - In WAIT, op_done advances the sequence and returns to ISSUE with the next command, so cmd_valid rises the cycle after op_done. Minimum spacing between accepts is 2 cycles.
  - op_done after the final STORE goes to FINISH.
- FINISH lasts one cycle: done=1, busy=0 on exit, then IDLE. The done pulse comes the cycle after the last op_done, or 1 cycle after start for an empty job.
- busy is high from the cycle after start through FINISH.
- Error cases (each sets err; the sequence is unaffected):
  - op_done in IDLE, ISSUE, FINISH, or in the accept cycle itself.
  - start while busy (the start is otherwise ignored).
- abort: next cycle state=IDLE, cmd_valid=0, busy=0, done is not pulsed; err and cmd_count hold. A datapath op still in flight is the host's responsibility.
- rst mid-job: all outputs return to reset values the next cycle; no done pulse.
- Index arithmetic:
  - Use IDX_WIDTH+1-bit compares so that Nq, Nkv = 2^IDX_WIDTH-1 work with no wrap.
  - min(i+1, Nkv) is computed without overflow.
- cmd_count saturates at 2^CNT_WIDTH-1.

Test Plan:
- Non-causal, Nq=2, Nkv=3, cmd_ready tied high, op_done 3 cycles after accept:
  - Exactly 36 accepts in order: LOAD_Q(0,0), then LOAD_K/QK/SOFTMAX/LOAD_V/PV for j=0..2, then NORM, STORE, repeated for i=1.
  - cmd_first only on j=0, cmd_last only on j=2.
  - done pulses once; cmd_count=36.
- Causal, Nq=3, Nkv=2:
  - J = 1, 2, 2, giving 34 commands in total.
  - Tile 0 carries cmd_first=cmd_last=1 on its single kv pass; no kv_idx ever exceeds q_idx.
- Nq=0 (and separately Nkv=0) with start: done the next cycle, busy high for 1 cycle, cmd_valid never asserted, cmd_count=0.
- Backpressure: hold cmd_ready low for 5 cycles on QK(i=1, j=2):
  - cmd_valid and all fields are stable for those 5 cycles.
  - A single accept occurs; cmd_count increments by exactly 1.
- Protocol errors:
  - op_done pulsed in IDLE gives err=1 and no commands.
  - start while busy gives err=1 and the sequence continues unchanged.
  - A subsequent start in IDLE clears err.
- Interruption:
  - abort during WAIT of LOAD_V(i=0, j=1): IDLE the next cycle, cmd_valid=0, no done.
  - rst asserted mid-ISSUE: all outputs at reset values the next cycle.
  - A new start then runs a full job correctly.
